divider_sequencer: RTL and testbench
====================================

Name: divider_sequencer

Overview:
- Controller for the pulse divider core.
- Accepts parallel configuration from a host: divide ratio, row length and number of rows.
- Serially loads the divider and row-length shift registers, arms the divider, then runs rows back to back. Between rows it inserts a disable gap and counts completed rows.
- Sits between the host/MCU register interface and the divider core's serial and enable pins.

Parameters:
- SR_WIDTH, 16, width of each configuration shift register and of the cfg words.
- SHIFT_HALF, 4, ctrl_clk cycles per sr_clk half-period (>=1).
- CLEAR_CYCLES, 4, ctrl_clk cycles sr_reset is held in CLEAR (>=1).
- GAP_CYCLES, 16, ctrl_clk cycles divide_enable is held low between rows (>=1).

Ports:
- ctrl_clk  in  1  system clock; all logic on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- cfg_divider  in  SR_WIDTH  divide ratio word, latched on start acceptance.
- cfg_row_len  in  SR_WIDTH  divided pulses per row, latched on start acceptance.
- cfg_row_count  in  16  rows to run; 0 = run until abort.
- cfg_start  in  1  start request, sampled only in IDLE.
- cfg_abort  in  1  abort, honoured in any state.
- row_completed  in  1  from divider core, asynchronous; 2-flop synchronized internally.
- sr_data  out  1  serial config data.
- sr_clk  out  1  serial config clock.
- sr_sel_div  out  1  divider SR select.
- sr_sel_row  out  1  row SR select.
- sr_reset  out  1  SR reset.
- divide_enable  out  1  divider output enable.
- en_rowpack  out  1  row-packing enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last row finishes.
- aborted  out  1  one-cycle pulse when an abort is taken from a non-IDLE state.
- rows_done  out  16  completed-row count for the current run.

Behaviour:
- Reset state: IDLE. All outputs 0; rows_done=0; synchronizer flops cleared. All outputs are registered.
- IDLE → CLEAR when cfg_start=1 and cfg_abort=0.
  - Latch all three cfg words.
  - Clear rows_done.
- CLEAR: sr_reset=1 for CLEAR_CYCLES cycles, then LOAD_DIV.
- LOAD_DIV: sr_sel_div=1 for the whole state; shifts SR_WIDTH bits of the latched divider word, MSB first.
  - Per bit: sr_clk=0 for SHIFT_HALF cycles with sr_data set to the bit at the start of the low phase.
  - Then sr_clk=1 for SHIFT_HALF cycles with sr_data held stable.
  - State lasts SR_WIDTH*2*SHIFT_HALF cycles; then LOAD_ROW.
- LOAD_ROW: identical timing with sr_sel_row=1 and the row-length word; then ARM.
- At every state boundary, sr_clk=0 and sr_data=0. The two sr_sel outputs are never high together.
- ARM: 1 cycle, all outputs idle-low; then RUN.
- RUN: divide_enable=1, en_rowpack=1.
  - A rising edge of synchronized row_completed increments rows_done (wraps at 0xFFFF).
  - If cfg_row_count≠0 and the new rows_done equals cfg_row_count → DONE.
  - Otherwise → GAP.
- GAP: divide_enable=0 and en_rowpack=0 for GAP_CYCLES cycles, then RUN.
  - row_completed edges during GAP are ignored.
  - The edge detector's history keeps updating during GAP, so a level still high on re-entry to RUN does not count.
- DONE: done=1 for 1 cycle, all enables 0; then IDLE. rows_done holds its value until the next start.
- cfg_abort=1 in any non-IDLE state:
  - Next cycle: state=IDLE, all serial/enable outputs 0, aborted=1 for 1 cycle, done not pulsed, rows_done holds.
  - Abort takes priority over every other transition, including a same-cycle row edge.
- cfg_start in a non-IDLE state is ignored.
- cfg_start and cfg_abort both high in IDLE: no start, no aborted pulse.
- ctrl_reset mid-operation: identical to the reset state above. No aborted pulse; rows_done=0.
- Latency with defaults, from the cycle cfg_start is accepted:
  - sr_reset rises 1 cycle later.
  - LOAD_DIV starts at +5.
  - LOAD_ROW starts at +133.
  - ARM at +261.
  - divide_enable rises at +262.
- Row-edge latency: a row_completed edge updates rows_done 3 cycles later (2 synchronizer flops + edge register).

Test Plan:
- Full load: defaults, cfg_divider=0xA5C3, cfg_row_len=0x0010 → capture sr_data on each sr_clk rise. Required: 16 bits 1010010111000011 with sr_sel_div=1, then 0000000000010000 with sr_sel_row=1; exactly 32 sr_clk rises; divide_enable rises at +262.
- Row sequencing: cfg_row_count=3, three row_completed pulses (each 5 cycles high) → divide_enable low for 16 cycles after rows 1 and 2; done pulses once after row 3; rows_done=3; busy falls with done.
- Infinite mode: cfg_row_count=0, five row pulses → rows_done=5, no done pulse, state stays RUN/GAP; then cfg_abort → aborted pulse, all outputs 0 next cycle, rows_done=5.
- Abort mid-shift: assert cfg_abort at +40 (inside LOAD_DIV) → next cycle sr_clk=0, sr_sel_div=0, busy=0, aborted=1; a later cfg_start performs a complete fresh load.
- Edge/gap rules: hold row_completed high through GAP and into RUN → only one increment; a pulse arriving during GAP → no increment; start+abort together in IDLE → remains IDLE, no pulses.
- Reset mid-RUN: ctrl_reset for 1 cycle with rows_done=2 → all outputs 0, rows_done=0, state IDLE, no aborted pulse.

Source files
------------

// File: rtl/divider_sequencer.sv
// Controller for the pulse divider core: latches a host configuration, serially loads the
// divider and row-length shift registers, then runs rows separated by disable gaps.
module divider_sequencer #(
    parameter int SR_WIDTH     = 16,
    parameter int SHIFT_HALF   = 4,
    parameter int CLEAR_CYCLES = 4,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                ctrl_clk,
    input  logic                ctrl_reset,
    input  logic [SR_WIDTH-1:0] cfg_divider,
    input  logic [SR_WIDTH-1:0] cfg_row_len,
    input  logic [15:0]         cfg_row_count,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                row_completed,
    output logic                sr_data,
    output logic                sr_clk,
    output logic                sr_sel_div,
    output logic                sr_sel_row,
    output logic                sr_reset,
    output logic                divide_enable,
    output logic                en_rowpack,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [15:0]         rows_done
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SHIFT_HALF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(SR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD_DIV, S_LOAD_ROW, S_ARM, S_RUN, S_GAP, S_DONE
    } state_t;

    state_t              state_q, state_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [CNT_W-1:0]    bit_q, bit_n;
    logic                phase_q, phase_n;
    logic [SR_WIDTH-1:0] shreg_q, shreg_n;
    logic [SR_WIDTH-1:0] div_q, row_q;
    logic [15:0]         count_q;
    logic [15:0]         rows_n;
    logic [1:0]          sync_q;
    logic                row_hist_q;
    logic                row_rise;
    logic                latch_cfg;
    logic                loading_n;

    logic sr_data_n, sr_clk_n, sr_sel_div_n, sr_sel_row_n, sr_reset_n;
    logic divide_enable_n, en_rowpack_n, busy_n, done_n, aborted_n;

    assign row_rise = sync_q[1] & ~row_hist_q;

    // Host handshake: cfg_start is a request taken only while busy=0 and cfg_abort=0; busy
    // stays high until the DONE or abort cycle completes, so no start is lost or double-taken.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_n     = bit_q;
        phase_n   = phase_q;
        shreg_n   = shreg_q;
        rows_n    = rows_done;
        latch_cfg = 1'b0;
        aborted_n = 1'b0;

        if (state_q != S_IDLE && cfg_abort) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        state_n   = S_CLEAR;
                        cnt_n     = '0;
                        rows_n    = '0;
                        latch_cfg = 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (cnt_q == CLEAR_LAST) begin
                        state_n = S_LOAD_DIV;
                        cnt_n   = '0;
                        bit_n   = '0;
                        phase_n = 1'b0;
                        shreg_n = div_q;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                S_LOAD_DIV, S_LOAD_ROW: begin
                    // Low half-period presents the bit, high half-period clocks it in.
                    if (cnt_q == HALF_LAST) begin
                        cnt_n = '0;
                        if (!phase_q) begin
                            phase_n = 1'b1;
                        end else begin
                            phase_n = 1'b0;
                            if (bit_q == BIT_LAST) begin
                                bit_n = '0;
                                if (state_q == S_LOAD_DIV) begin
                                    state_n = S_LOAD_ROW;
                                    shreg_n = row_q;
                                end else begin
                                    state_n = S_ARM;
                                    shreg_n = '0;
                                end
                            end else begin
                                bit_n   = bit_q + 1'b1;
                                shreg_n = shreg_q << 1;
                            end
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                S_ARM: state_n = S_RUN;
                S_RUN: begin
                    if (row_rise) begin
                        rows_n = rows_done + 16'd1;
                        cnt_n  = '0;
                        if (count_q != 16'd0 && rows_n == count_q) state_n = S_DONE;
                        else state_n = S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) state_n = S_RUN;
                    else cnt_n = cnt_q + 1'b1;
                end
                S_DONE:  state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so the registered pins line up with state_q.
        loading_n       = (state_n == S_LOAD_DIV) || (state_n == S_LOAD_ROW);
        sr_data_n       = loading_n & shreg_n[SR_WIDTH-1];
        sr_clk_n        = loading_n & phase_n;
        sr_sel_div_n    = (state_n == S_LOAD_DIV);
        sr_sel_row_n    = (state_n == S_LOAD_ROW);
        sr_reset_n      = (state_n == S_CLEAR);
        divide_enable_n = (state_n == S_RUN);
        en_rowpack_n    = (state_n == S_RUN);
        busy_n          = (state_n != S_IDLE);
        done_n          = (state_n == S_DONE);
    end

    always_ff @(posedge ctrl_clk) begin
        if (ctrl_reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            phase_q       <= 1'b0;
            shreg_q       <= '0;
            div_q         <= '0;
            row_q         <= '0;
            count_q       <= '0;
            rows_done     <= '0;
            sync_q        <= '0;
            row_hist_q    <= 1'b0;
            sr_data       <= 1'b0;
            sr_clk        <= 1'b0;
            sr_sel_div    <= 1'b0;
            sr_sel_row    <= 1'b0;
            sr_reset      <= 1'b0;
            divide_enable <= 1'b0;
            en_rowpack    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            bit_q      <= bit_n;
            phase_q    <= phase_n;
            shreg_q    <= shreg_n;
            rows_done  <= rows_n;
            sync_q     <= {sync_q[0], row_completed};
            // History tracks in every state, so a level held across GAP is not a new edge.
            row_hist_q <= sync_q[1];
            if (latch_cfg) begin
                div_q   <= cfg_divider;
                row_q   <= cfg_row_len;
                count_q <= cfg_row_count;
            end
            sr_data       <= sr_data_n;
            sr_clk        <= sr_clk_n;
            sr_sel_div    <= sr_sel_div_n;
            sr_sel_row    <= sr_sel_row_n;
            sr_reset      <= sr_reset_n;
            divide_enable <= divide_enable_n;
            en_rowpack    <= en_rowpack_n;
            busy          <= busy_n;
            done          <= done_n;
            aborted       <= aborted_n;
        end
    end
endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer: randomized configs checked against timing and serial-bit
// expectations derived from the configuration words and the documented latencies.
module tb_divider_sequencer;
    localparam int SR_WIDTH     = 16;
    localparam int SHIFT_HALF   = 4;
    localparam int CLEAR_CYCLES = 4;
    localparam int GAP_CYCLES   = 16;
    localparam int LOAD_LEN     = SR_WIDTH * 2 * SHIFT_HALF;
    localparam int T_CLEAR      = 1;
    localparam int T_DIV        = T_CLEAR + CLEAR_CYCLES;
    localparam int T_ROW        = T_DIV + LOAD_LEN;
    localparam int T_ARM        = T_ROW + LOAD_LEN;
    localparam int T_RUN        = T_ARM + 1;
    localparam int ROW_LAT      = 3;

    localparam int I_SEL_DIV = 7, I_SEL_ROW = 6, I_SR_RESET = 5, I_DE = 4;
    localparam logic [9:0] M_BUSY  = 10'h004;
    localparam logic [9:0] M_CLEAR = 10'h024;
    localparam logic [9:0] M_RUN   = 10'h01C;
    localparam logic [9:0] M_DONE  = 10'h006;
    localparam logic [9:0] M_ABORT = 10'h001;

    logic        ctrl_clk = 1'b0;
    logic        ctrl_reset;
    logic [15:0] cfg_divider, cfg_row_len, cfg_row_count;
    logic        cfg_start, cfg_abort, row_completed;
    logic        sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset;
    logic        divide_enable, en_rowpack, busy, done, aborted;
    logic [15:0] rows_done;
    logic [9:0]  outs;

    divider_sequencer #(
        .SR_WIDTH(SR_WIDTH), .SHIFT_HALF(SHIFT_HALF),
        .CLEAR_CYCLES(CLEAR_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset),
        .cfg_divider(cfg_divider), .cfg_row_len(cfg_row_len), .cfg_row_count(cfg_row_count),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort), .row_completed(row_completed),
        .sr_data(sr_data), .sr_clk(sr_clk), .sr_sel_div(sr_sel_div), .sr_sel_row(sr_sel_row),
        .sr_reset(sr_reset), .divide_enable(divide_enable), .en_rowpack(en_rowpack),
        .busy(busy), .done(done), .aborted(aborted), .rows_done(rows_done)
    );

    assign outs = {sr_data, sr_clk, sr_sel_div, sr_sel_row, sr_reset,
                   divide_enable, en_rowpack, busy, done, aborted};

    // Clock and cycle counter
    always #5 ctrl_clk = ~ctrl_clk;
    int edge_cnt = 0;
    always @(posedge ctrl_clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: expected {sel_div, sel_row, data} at each sr_clk rise
    logic [2:0]  exp_q[$];
    int          gap_q[$];
    logic        sb_en = 1'b1;
    int          clk_rises = 0, done_cnt = 0, abort_cnt = 0, low_len = 0;
    logic        clk_prev = 1'b0, de_prev = 1'b0, done_prev = 1'b0, abort_prev = 1'b0;
    logic        gap_open = 1'b0, busy_after_done = 1'b1;
    logic [15:0] rows_at_done = '0;
    logic [9:0]  outs_at_done = '0;

    task automatic monitor_step();
        logic [2:0] e;
        check_eq("sel_exclusive", 32'(sr_sel_div & sr_sel_row), 32'd0);
        check_eq("done_width", 32'(done & done_prev), 32'd0);
        check_eq("aborted_width", 32'(aborted & abort_prev), 32'd0);
        if (sr_clk && !clk_prev) begin
            clk_rises++;
            if (sb_en) begin
                check_eq("sr_rise_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("sr_bit", 32'({sr_sel_div, sr_sel_row, sr_data}), 32'(e));
                end
            end
        end
        if (done && !done_prev) begin
            done_cnt++;
            rows_at_done = rows_done;
            outs_at_done = outs;
        end
        if (done_prev) busy_after_done = busy;
        if (aborted && !abort_prev) abort_cnt++;
        if (!busy) gap_open = 1'b0;
        else if (de_prev && !divide_enable) begin gap_open = 1'b1; low_len = 1; end
        else if (gap_open && !divide_enable) low_len++;
        else if (gap_open && divide_enable) begin gap_q.push_back(low_len); gap_open = 1'b0; end
        clk_prev   = sr_clk;
        de_prev    = divide_enable;
        done_prev  = done;
        abort_prev = aborted;
    endtask

    initial forever begin
        @(negedge ctrl_clk);
        monitor_step();
    end

    // Driver tasks (all driving happens at the falling edge)
    int start_edge = 0;

    task automatic idle(input int n);
        repeat (n) @(negedge ctrl_clk);
    endtask

    task automatic do_start(input logic [15:0] d, input logic [15:0] r, input logic [15:0] c);
        cfg_divider = d; cfg_row_len = r; cfg_row_count = c;
        cfg_start = 1'b1;
        start_edge = edge_cnt;
        @(negedge ctrl_clk);
        cfg_start = 1'b0;
    endtask

    task automatic push_load(input logic [15:0] d, input logic [15:0] r);
        for (int i = SR_WIDTH - 1; i >= 0; i--) exp_q.push_back({1'b1, 1'b0, d[i]});
        for (int i = SR_WIDTH - 1; i >= 0; i--) exp_q.push_back({1'b0, 1'b1, r[i]});
    endtask

    task automatic wait_level(input int idx, input logic lvl, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (outs[idx] == lvl) begin
                lat = edge_cnt - start_edge;
                return;
            end
            @(negedge ctrl_clk);
        end
    endtask

    task automatic row_pulse(input int hi_len, input int obs, output int lat);
        int k;
        logic [15:0] old;
        k = edge_cnt; old = rows_done; lat = -1;
        row_completed = 1'b1;
        for (int i = 1; i <= obs; i++) begin
            @(negedge ctrl_clk);
            if (lat < 0 && rows_done != old) lat = edge_cnt - k;
            if (i == hi_len) row_completed = 1'b0;
        end
    endtask

    task automatic run_load(input logic [15:0] d, input logic [15:0] r, input logic [15:0] c);
        int lat, base;
        gap_q.delete();
        push_load(d, r);
        base = clk_rises;
        do_start(d, r, c);
        wait_level(I_SR_RESET, 1'b1, 10, lat);
        check_eq("lat_sr_reset", 32'(lat), 32'(T_CLEAR));
        check_eq("clear_outs", 32'(outs), 32'(M_CLEAR));
        wait_level(I_SEL_DIV, 1'b1, 20, lat);
        check_eq("lat_load_div", 32'(lat), 32'(T_DIV));
        wait_level(I_SEL_ROW, 1'b1, LOAD_LEN + 20, lat);
        check_eq("lat_load_row", 32'(lat), 32'(T_ROW));
        wait_level(I_SEL_ROW, 1'b0, LOAD_LEN + 20, lat);
        check_eq("lat_arm", 32'(lat), 32'(T_ARM));
        check_eq("arm_outs", 32'(outs), 32'(M_BUSY));
        wait_level(I_DE, 1'b1, 10, lat);
        check_eq("lat_run", 32'(lat), 32'(T_RUN));
        check_eq("run_outs", 32'(outs), 32'(M_RUN));
        check_eq("sr_clk_rises", 32'(clk_rises - base), 32'(2 * SR_WIDTH));
        check_eq("sr_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic counted_row(input int exp_rows);
        int lat;
        wait_level(I_DE, 1'b1, 3 * GAP_CYCLES, lat);
        check_eq("run_reentry", 32'(lat >= 0), 32'd1);
        idle($urandom_range(1, 8));
        row_pulse(5, 12, lat);
        check_eq("row_latency", 32'(lat), 32'(ROW_LAT));
        check_eq("rows_done", 32'(rows_done), 32'(exp_rows));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ab, dn, g;
        logic [15:0] d, r;
        ctrl_reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; row_completed = 1'b0;
        cfg_divider = '0; cfg_row_len = '0; cfg_row_count = '0;
        idle(3);
        check_eq("reset_outs", 32'(outs), 32'd0);
        check_eq("reset_rows", 32'(rows_done), 32'd0);
        ctrl_reset = 1'b0;
        idle(1);
        check_eq("idle_outs", 32'(outs), 32'd0);

        // Full load with the reference words, then three counted rows
        run_load(16'hA5C3, 16'h0010, 16'd3);
        dn = done_cnt;
        for (int i = 1; i <= 3; i++) counted_row(i);
        check_eq("done_pulses", 32'(done_cnt - dn), 32'd1);
        check_eq("rows_at_done", 32'(rows_at_done), 32'd3);
        check_eq("outs_at_done", 32'(outs_at_done), 32'(M_DONE));
        check_eq("busy_after_done", 32'(busy_after_done), 32'd0);
        check_eq("rows_hold_after_done", 32'(rows_done), 32'd3);
        check_eq("idle_after_done", 32'(outs), 32'd0);
        check_eq("gap_count", 32'(gap_q.size()), 32'd2);
        while (gap_q.size() != 0) begin
            g = gap_q.pop_front();
            check_eq("gap_len", 32'(g), 32'(GAP_CYCLES));
        end

        // Start and abort together in IDLE
        ab = abort_cnt;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        idle(1);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        check_eq("start_abort_idle", 32'(outs), 32'd0);
        idle(3);
        check_eq("start_abort_stays", 32'(outs), 32'd0);
        check_eq("start_abort_no_pulse", 32'(abort_cnt - ab), 32'd0);

        // Infinite mode with random words and edge/gap rules
        d = 16'($urandom_range(0, 65535));
        r = 16'($urandom_range(0, 65535));
        run_load(d, r, 16'd0);
        dn = done_cnt;
        counted_row(1);
        counted_row(2);
        wait_level(I_DE, 1'b1, 3 * GAP_CYCLES, lat);
        cfg_divider = 16'($urandom_range(0, 65535));
        cfg_start = 1'b1;
        idle(1);
        cfg_start = 1'b0;
        idle(4);
        check_eq("start_ignored_run", 32'(outs), 32'(M_RUN));
        check_eq("start_ignored_rows", 32'(rows_done), 32'd2);
        idle($urandom_range(1, 8));
        row_pulse(30, 40, lat);
        check_eq("hold_latency", 32'(lat), 32'(ROW_LAT));
        check_eq("hold_single_count", 32'(rows_done), 32'd3);
        wait_level(I_DE, 1'b1, 3 * GAP_CYCLES, lat);
        idle($urandom_range(1, 8));
        row_pulse(5, 6, lat);
        check_eq("row4_latency", 32'(lat), 32'(ROW_LAT));
        row_pulse(3, 10, lat);
        check_eq("gap_pulse_in_gap", 32'(divide_enable), 32'd0);
        check_eq("gap_pulse_ignored", 32'(lat), 32'hFFFF_FFFF);
        check_eq("rows_after_gap_pulse", 32'(rows_done), 32'd4);
        counted_row(5);
        check_eq("infinite_no_done", 32'(done_cnt - dn), 32'd0);
        check_eq("infinite_busy", 32'(busy), 32'd1);
        idle($urandom_range(0, 15));
        check_eq("gap_count_inf", 32'(gap_q.size() >= 4), 32'd1);
        while (gap_q.size() != 0) begin
            g = gap_q.pop_front();
            check_eq("gap_len_inf", 32'(g), 32'(GAP_CYCLES));
        end
        ab = abort_cnt;
        cfg_abort = 1'b1;
        idle(1);
        cfg_abort = 1'b0;
        check_eq("abort_outs", 32'(outs), 32'(M_ABORT));
        check_eq("abort_rows_hold", 32'(rows_done), 32'd5);
        idle(1);
        check_eq("abort_clears", 32'(outs), 32'd0);
        check_eq("abort_pulses", 32'(abort_cnt - ab), 32'd1);

        // Abort in the middle of the divider shift, then a complete fresh load
        sb_en = 1'b0;
        do_start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'd0);
        while (edge_cnt - start_edge < 40) @(negedge ctrl_clk);
        check_eq("mid_shift_sel_div", 32'(sr_sel_div), 32'd1);
        cfg_abort = 1'b1;
        idle(1);
        cfg_abort = 1'b0;
        check_eq("mid_shift_abort_outs", 32'(outs), 32'(M_ABORT));
        idle(1);
        sb_en = 1'b1;
        check_eq("mid_shift_idle", 32'(outs), 32'd0);
        d = 16'($urandom_range(0, 65535));
        r = 16'($urandom_range(0, 65535));
        run_load(d, r, 16'($urandom_range(3, 9)));
        check_eq("fresh_rows_clear", 32'(rows_done), 32'd0);

        // Reset in the middle of RUN
        counted_row(1);
        counted_row(2);
        wait_level(I_DE, 1'b1, 3 * GAP_CYCLES, lat);
        idle($urandom_range(1, 8));
        ab = abort_cnt;
        ctrl_reset = 1'b1;
        idle(1);
        check_eq("reset_run_outs", 32'(outs), 32'd0);
        check_eq("reset_run_rows", 32'(rows_done), 32'd0);
        ctrl_reset = 1'b0;
        idle(2);
        check_eq("reset_run_idle", 32'(outs), 32'd0);
        check_eq("reset_run_no_abort", 32'(abort_cnt - ab), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
